// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode tags and flag bit positions.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int FLAG_W    = 2;

  // Flag bit positions inside the 2-bit {N, Z} flag field.
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    PASS = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    AND  = 3'd3,
    OR   = 3'd4,
    XOR  = 3'd5,
    NOT  = 3'd6,
    SHL  = 3'd7
  } alu_op_t;

endpackage

// File: rtl/alu_result_fifo_4bit_if.sv
// Push/pop handshake bundle between the ALU, the result FIFO and its reader.
interface alu_result_fifo_4bit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_result;
  alu_op_t           in_op;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  alu_op_t           out_op;
  logic [FLAG_W-1:0] out_flags;
  logic [LVL_W-1:0]  level;

  // FIFO side
  modport slave (
    input  clear, in_valid, in_result, in_op, out_ready,
    output in_ready, out_valid, out_result, out_op, out_flags, level
  );

  // Producer/consumer side
  modport master (
    output clear, in_valid, in_result, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_flags, level
  );
endinterface

// File: rtl/alu_flags_4bit.sv
// Combinational {N, Z} flag derivation from a signed result.
module alu_flags_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  // N is the sign bit, Z is an all-zero result
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/alu_result_fifo_4bit.sv
// Circular-buffer FIFO for ALU results with opcode tag and push-time flags.
// Handshake outputs come from registered state only; no bypass when full.
module alu_result_fifo_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  alu_result_fifo_4bit_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]  wptr, rptr;
  logic [LVL_W-1:0]  lvl;
  logic [FLAG_W-1:0] in_flags;
  logic              push, pop;

  logic [WIDTH-1:0]  res_mem  [DEPTH];
  alu_op_t           op_mem   [DEPTH];
  logic [FLAG_W-1:0] flag_mem [DEPTH];

  alu_flags_4bit #(.WIDTH(WIDTH)) u_flags (
    .result (bus.in_result),
    .flags  (in_flags)
  );

  assign bus.in_ready  = (lvl != FULL_LVL);
  assign bus.out_valid = (lvl != '0);
  assign bus.level     = lvl;

  // clear takes priority and swallows any same-cycle transfer
  assign push = bus.in_valid  && bus.in_ready  && !bus.clear;
  assign pop  = bus.out_ready && bus.out_valid && !bus.clear;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else if (bus.clear) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   lvl <= lvl + LVL_W'(1);
        2'b01:   lvl <= lvl - LVL_W'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // Entry storage; contents are qualified by lvl so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wptr]  <= bus.in_result;
      op_mem[wptr]   <= bus.in_op;
      flag_mem[wptr] <= in_flags;
    end
  end

  // Head data is forced to zero whenever the FIFO is empty
  always_comb begin
    bus.out_result = '0;
    bus.out_op     = PASS;
    bus.out_flags  = '0;
    if (bus.out_valid) begin
      bus.out_result = res_mem[rptr];
      bus.out_op     = op_mem[rptr];
      bus.out_flags  = flag_mem[rptr];
    end
  end

endmodule

// File: tb/tb_alu_result_fifo_4bit.sv
// Self-checking bench for alu_result_fifo_4bit with a queue-based reference model.
module tb_alu_result_fifo_4bit;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  typedef struct {
    logic [3:0] r;
    logic [2:0] op;
  } ent_t;
  ent_t q[$];

  alu_result_fifo_4bit_if #(.WIDTH(4), .DEPTH(DEPTH)) bus ();

  alu_result_fifo_4bit #(.WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] mflags(input logic [3:0] r);
    return {r[3], (r == 4'd0)};
  endfunction

  // One clock of stimulus; the model applies the FIFO rules to the queue.
  task automatic cyc(input logic v, input logic [3:0] r, input logic [2:0] op,
                     input logic rdy, input logic clr);
    bit pu, po;
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_op     = alu_op_t'(op);
    bus.out_ready = rdy;
    bus.clear     = clr;
    if (clr) q.delete();
    else begin
      pu = v && (q.size() < DEPTH);
      po = rdy && (q.size() > 0);
      if (po) void'(q.pop_front());
      if (pu) q.push_back('{r: r, op: op});
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.level !== 3'd0) $display("FAIL rst_level got=%0d exp=0", bus.level); else pass_cnt++;
    total_cnt++; if (bus.out_result !== 4'd0 || bus.out_flags !== 2'd0)
      $display("FAIL rst_data got=%b/%b exp=0000/00", bus.out_result, bus.out_flags); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    cyc(1'b1, 4'b1111, PASS, 1'b0, 1'b0);
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL first_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_result !== 4'b1111) $display("FAIL first_result got=%b exp=1111", bus.out_result); else pass_cnt++;
    total_cnt++; if (bus.out_flags !== 2'b10) $display("FAIL first_flags got=%b exp=10", bus.out_flags); else pass_cnt++;
    total_cnt++; if (bus.out_op !== PASS) $display("FAIL first_op got=%0d exp=0", bus.out_op); else pass_cnt++;
    total_cnt++; if (bus.level !== 3'd1) $display("FAIL first_level got=%0d exp=1", bus.level); else pass_cnt++;
  endtask

  task automatic test_fill;
    logic [3:0] v[4];
    logic [1:0] f[4];
    v = '{4'b0000, 4'b1010, 4'b0111, 4'b1000};
    f = '{2'b01, 2'b10, 2'b00, 2'b10};
    cyc(1'b0, 4'd0, PASS, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, v[i], 3'(i + 1), 1'b0, 1'b0);
    total_cnt++; if (bus.level !== 3'd4) $display("FAIL fill_level got=%0d exp=4", bus.level); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
    cyc(1'b1, 4'b0101, XOR, 1'b0, 1'b0);
    total_cnt++; if (bus.level !== 3'd4) $display("FAIL fifth_push_level got=%0d exp=4", bus.level); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (bus.out_result !== v[i] || bus.out_flags !== f[i] || bus.out_op !== alu_op_t'(i + 1))
        $display("FAIL drain%0d got=%b/%b/%0d exp=%b/%b/%0d", i, bus.out_result, bus.out_flags, bus.out_op, v[i], f[i], i + 1);
      else pass_cnt++;
      cyc(1'b0, 4'd0, PASS, 1'b1, 1'b0);
    end
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_result !== 4'd0)
      $display("FAIL drain_empty got=%b/%b exp=0/0000", bus.out_valid, bus.out_result); else pass_cnt++;
  endtask

  task automatic test_stream;
    logic [3:0] v[10];
    for (int i = 0; i < 10; i++) v[i] = 4'($urandom);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, v[i], 3'($urandom), 1'b1, 1'b0);
      total_cnt++; if (bus.level !== 3'd1 || bus.out_result !== v[i] || bus.out_flags !== mflags(v[i]))
        $display("FAIL stream%0d got=lvl%0d %b/%b exp=lvl1 %b/%b", i, bus.level, bus.out_result, bus.out_flags, v[i], mflags(v[i]));
      else pass_cnt++;
    end
    cyc(1'b0, 4'd0, PASS, 1'b1, 1'b0);
    total_cnt++; if (bus.level !== 3'd0) $display("FAIL stream_drain got=%0d exp=0", bus.level); else pass_cnt++;
  endtask

  task automatic test_full_pushpop;
    logic [3:0] v[4];
    for (int i = 0; i < 4; i++) begin
      v[i] = 4'($urandom);
      cyc(1'b1, v[i], SUB, 1'b0, 1'b0);
    end
    cyc(1'b1, ~v[0], ADD, 1'b1, 1'b0);
    total_cnt++; if (bus.level !== 3'd3) $display("FAIL full_pp_level got=%0d exp=3", bus.level); else pass_cnt++;
    total_cnt++; if (bus.out_result !== v[1]) $display("FAIL full_pp_head got=%b exp=%b", bus.out_result, v[1]); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL full_pp_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_clear;
    cyc(1'b1, 4'b0110, AND, 1'b1, 1'b1);
    total_cnt++; if (bus.level !== 3'd0 || bus.out_valid !== 1'b0)
      $display("FAIL clear got=lvl%0d v%b exp=lvl0 v0", bus.level, bus.out_valid); else pass_cnt++;
    cyc(1'b1, 4'b0011, OR, 1'b0, 1'b0);
    total_cnt++; if (bus.out_result !== 4'b0011 || bus.level !== 3'd1 || bus.out_flags !== 2'b00)
      $display("FAIL clear_push got=%b lvl%0d f%b exp=0011 lvl1 f00", bus.out_result, bus.level, bus.out_flags); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 4'b1001, SHL, 1'b0, 1'b0);
    total_cnt++; if (bus.level !== 3'd2) $display("FAIL async_pre got=%0d exp=2", bus.level); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.in_ready !== 1'b1 || bus.out_result !== 4'd0)
      $display("FAIL async_rst got=v%b lvl%0d r%b d%b exp=v0 lvl0 r1 d0000", bus.out_valid, bus.level, bus.in_ready, bus.out_result);
    else pass_cnt++;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [3:0] er;
    logic [2:0] eo;
    logic [1:0] ef;
    for (int n = 0; n < 300; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      er = (q.size() != 0) ? q[0].r : 4'd0;
      eo = (q.size() != 0) ? q[0].op : 3'd0;
      ef = (q.size() != 0) ? mflags(q[0].r) : 2'd0;
      total_cnt++;
      if (bus.level !== 3'(q.size()) || bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() != DEPTH) ||
          bus.out_result !== er || bus.out_op !== alu_op_t'(eo) || bus.out_flags !== ef)
        $display("FAIL random%0d got=lvl%0d v%b r%b %b/%0d/%b exp=lvl%0d %b/%0d/%b",
                 n, bus.level, bus.out_valid, bus.in_ready, bus.out_result, bus.out_op, bus.out_flags,
                 q.size(), er, eo, ef);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_result = 4'd0;
    bus.in_op     = PASS;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill();
    test_stream();
    test_full_pushpop();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
